temp_frame_tx: RTL and testbench

TEMP_FRAME_TX -- requirements
Module: temp_frame_tx

---
 rtl/temp_frame_tx.sv | 166 ++++++++++++++++
 tb/tb_temp_frame_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/temp_frame_tx.sv
// Packs averaged temperature samples into 6-byte UART frames: header, seq, sample lo/hi, status, XOR checksum.
// Latency: the frame starts one cycle after capture; each byte costs LOAD + START plus the UART busy time.
// Backpressure: paced by tx_busy; one-deep pending buffer, later samples overwrite it and are counted as drops.
module temp_frame_tx #(
    parameter logic [7:0] HEADER = 8'hA5,
    parameter int         DROP_W = 8
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sample_valid,
    input  logic [15:0]       sample,
    input  logic              temp_warn,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              frame_busy,
    output logic              frame_done,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        START   = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t      state;
    logic [2:0]  idx;
    logic [7:0]  seq;
    logic [15:0] act_sample;
    logic        act_warn;
    logic [15:0] pend_sample;
    logic        pend_warn;
    logic        pend_vld;
    logic        ovr_flag;
    logic        frame_ovr;

    logic        wr_pend;
    logic        drop;
    logic        load_hdr_go;
    logic [2:0]  idx_inc;
    logic [7:0]  status_byte;
    logic [7:0]  checksum;
    logic [7:0]  next_byte;

    always_comb begin
        wr_pend     = en && sample_valid && (state != IDLE);
        drop        = wr_pend && pend_vld;
        // ovr is snapshotted only on the cycle the header byte actually leaves LOAD
        load_hdr_go = (state == LOAD) && (idx == 3'd0) && !tx_busy;
        idx_inc     = idx + 3'd1;
        status_byte = {act_warn, 6'b0, frame_ovr};
        checksum    = HEADER ^ seq ^ act_sample[7:0] ^ act_sample[15:8] ^ status_byte;
        case (idx_inc)
            3'd1:    next_byte = seq;
            3'd2:    next_byte = act_sample[7:0];
            3'd3:    next_byte = act_sample[15:8];
            3'd4:    next_byte = status_byte;
            3'd5:    next_byte = checksum;
            default: next_byte = HEADER;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= 3'd0;
            seq         <= 8'd0;
            act_sample  <= 16'd0;
            act_warn    <= 1'b0;
            pend_sample <= 16'd0;
            pend_warn   <= 1'b0;
            pend_vld    <= 1'b0;
            ovr_flag    <= 1'b0;
            frame_ovr   <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= 8'd0;
            frame_busy  <= 1'b0;
            frame_done  <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            tx_start   <= 1'b0;
            frame_done <= 1'b0;

            // DONE consumes a coincident sample directly, so it never lands in pending there
            if (wr_pend && (state != DONE)) begin
                pend_sample <= sample;
                pend_warn   <= temp_warn;
                pend_vld    <= 1'b1;
            end

            if (drop) begin
                ovr_flag <= 1'b1;
                if (drop_cnt != '1)
                    drop_cnt <= drop_cnt + {{(DROP_W-1){1'b0}}, 1'b1};
            end else if (load_hdr_go) begin
                ovr_flag <= 1'b0;
            end

            if (load_hdr_go)
                frame_ovr <= ovr_flag;

            case (state)
                IDLE: begin
                    if (en && sample_valid) begin
                        act_sample <= sample;
                        act_warn   <= temp_warn;
                        idx        <= 3'd0;
                        tx_data    <= HEADER;
                        frame_busy <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    // never request while the UART still reports busy
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (tx_busy)
                        state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (idx < 3'd5) begin
                            idx     <= idx_inc;
                            tx_data <= next_byte;
                            state   <= LOAD;
                        end else begin
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    seq <= seq + 8'd1;
                    if (pend_vld || wr_pend) begin
                        act_sample <= wr_pend ? sample : pend_sample;
                        act_warn   <= wr_pend ? temp_warn : pend_warn;
                        pend_vld   <= 1'b0;
                        idx        <= 3'd0;
                        tx_data    <= HEADER;
                        state      <= LOAD;
                    end else begin
                        frame_busy <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    frame_busy <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_temp_frame_tx.sv
// Directed bench for temp_frame_tx with a 10-cycle-per-byte UART model.
module tb_temp_frame_tx;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        en;
    logic        sample_valid;
    logic [15:0] sample;
    logic        temp_warn;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        frame_busy;
    logic        frame_done;
    logic [7:0]  drop_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int viol = 0;
    logic [7:0] rx_q[$];
    int uart_cnt;

    temp_frame_tx #(.HEADER(8'hA5), .DROP_W(8)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .en(en), .sample_valid(sample_valid),
        .sample(sample), .temp_warn(temp_warn), .tx_busy(tx_busy),
        .tx_start(tx_start), .tx_data(tx_data), .frame_busy(frame_busy),
        .frame_done(frame_done), .drop_cnt(drop_cnt)
    );

    always #5 clk_in = ~clk_in;

    // UART: busy for 10 cycles after each accepted tx_start
    always @(posedge clk_in) begin
        if (!rst_n) begin
            tx_busy  <= 1'b0;
            uart_cnt <= 0;
        end else if (tx_start && !tx_busy) begin
            tx_busy  <= 1'b1;
            uart_cnt <= 9;
        end else if (tx_busy) begin
            if (uart_cnt == 0) tx_busy <= 1'b0;
            else uart_cnt <= uart_cnt - 1;
        end
    end

    always @(posedge clk_in) begin
        if (tx_start) begin
            rx_q.push_back(tx_data);
            if (tx_busy) viol++;
        end
        if (frame_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input int base, input logic [47:0] exp);
        logic [7:0] b;
        chk({tag, " size"}, rx_q.size() >= base + 6, 1);
        for (int i = 0; i < 6; i++) begin
            b = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
            chk($sformatf("%s byte%0d", tag, i), b, exp[47 - 8*i -: 8]);
        end
    endtask

    task automatic pulse(input logic [15:0] s, input logic w);
        @(negedge clk_in);
        sample = s;
        temp_warn = w;
        sample_valid = 1'b1;
        @(negedge clk_in);
        sample_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (done_cnt < target && n < 40000) begin
            @(negedge clk_in);
            n++;
        end
        chk(tag, done_cnt, target);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        en = 1'b0;
        sample_valid = 1'b0;
        sample = 16'd0;
        temp_warn = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("rst tx_start", tx_start, 0);
        chk("rst tx_data", tx_data, 0);
        chk("rst frame_busy", frame_busy, 0);
        chk("rst frame_done", frame_done, 0);
        chk("rst drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        en = 1'b1;

        // first frame, seq 0
        rx_q.delete();
        pulse(16'h1234, 1'b0);
        chk("f0 busy after capture", frame_busy, 1);
        chk("f0 tx_data header", tx_data, 8'hA5);
        wait_done(1, "f0 done");
        chk_frame("f0", 0, {8'hA5, 8'h00, 8'h34, 8'h12, 8'h00, 8'h83});
        repeat (3) @(negedge clk_in);
        chk("f0 idle after", frame_busy, 0);
        chk("f0 single done", done_cnt, 1);

        // second frame, seq 1, warn set
        rx_q.delete();
        pulse(16'hFFFF, 1'b1);
        wait_done(2, "f1 done");
        chk_frame("f1", 0, {8'hA5, 8'h01, 8'hFF, 8'hFF, 8'h80, 8'h24});

        // 1 starts a frame, 2 and 3 arrive mid-frame; en then drops but pending survives
        rx_q.delete();
        pulse(16'h0001, 1'b0);
        repeat (5) @(negedge clk_in);
        pulse(16'h0002, 1'b0);
        pulse(16'h0003, 1'b0);
        en = 1'b0;
        wait_done(4, "ovr frames done");
        chk("ovr byte count", rx_q.size(), 12);
        chk_frame("f2", 0, {8'hA5, 8'h02, 8'h01, 8'h00, 8'h00, 8'hA6});
        chk_frame("f3", 6, {8'hA5, 8'h03, 8'h03, 8'h00, 8'h01, 8'hA4});
        chk("drop_cnt one", drop_cnt, 1);
        repeat (5) @(negedge clk_in);
        chk("ovr idle after", frame_busy, 0);

        // sample arriving exactly on the DONE cycle
        en = 1'b1;
        rx_q.delete();
        pulse(16'h0055, 1'b0);
        n = 0;
        while (!frame_done && n < 5000) begin
            @(negedge clk_in);
            n++;
        end
        chk("done cycle seen", frame_done, 1);
        sample = 16'h00AA;
        temp_warn = 1'b0;
        sample_valid = 1'b1;
        @(negedge clk_in);
        sample_valid = 1'b0;
        chk("no gap busy", frame_busy, 1);
        chk("no gap header", tx_data, 8'hA5);
        wait_done(6, "back2back done");
        chk_frame("f4", 0, {8'hA5, 8'h04, 8'h55, 8'h00, 8'h00, 8'hF4});
        chk_frame("f5", 6, {8'hA5, 8'h05, 8'hAA, 8'h00, 8'h00, 8'h0A});
        chk("no drop on done", drop_cnt, 1);

        // continuous valid: frames chain back to back, drops saturate, seq wraps
        @(negedge clk_in);
        sample = 16'h0000;
        temp_warn = 1'b0;
        sample_valid = 1'b1;
        n = 0;
        while (done_cnt < 256 && n < 40000) begin
            @(negedge clk_in);
            n++;
        end
        sample_valid = 1'b0;
        rx_q.delete();
        chk("256 frames", done_cnt, 256);
        chk("drop_cnt saturated", drop_cnt, 8'hFF);
        wait_done(257, "wrap frame done");
        chk_frame("wrap", 0, {8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'hA4});
        chk("drop_cnt holds", drop_cnt, 8'hFF);
        chk("tx_start while busy", viol, 0);

        // reset in WAIT_LO of byte 3
        rx_q.delete();
        pulse(16'h4321, 1'b0);
        n = 0;
        while (rx_q.size() < 4 && n < 2000) begin
            @(negedge clk_in);
            n++;
        end
        chk("reach byte3", rx_q.size(), 4);
        repeat (4) @(negedge clk_in);
        rst_n = 1'b0;
        @(negedge clk_in);
        chk("mid rst tx_start", tx_start, 0);
        chk("mid rst tx_data", tx_data, 0);
        chk("mid rst frame_busy", frame_busy, 0);
        chk("mid rst frame_done", frame_done, 0);
        chk("mid rst drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        repeat (30) @(negedge clk_in);
        chk("no tx after rst", rx_q.size(), 4);

        // en low ignores samples entirely
        en = 1'b0;
        pulse(16'h7777, 1'b1);
        repeat (5) @(negedge clk_in);
        chk("en0 idle", frame_busy, 0);
        chk("en0 no tx", rx_q.size(), 4);
        chk("en0 drop", drop_cnt, 0);

        en = 1'b1;
        rx_q.delete();
        pulse(16'h0000, 1'b0);
        wait_done(258, "post rst done");
        chk_frame("postrst", 0, {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
